alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Initiator side of the ALU control/operand interface: accepts decoded-instruction requests over a valid/ready handshake.
- Encodes MIPS opcode/funct into the 5-bit ALU control code, drives the combinational ALU's control and operand inputs from a register stage, then captures the ALU result into a response register.
- Sits between the instruction decode stage and the combinational ALU in the execute stage.
- Two-stage pipeline: full throughput (one request per cycle) when the response side is not back-pressured.

Parameters:
- ID_W, 4, width of the request/response tag.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_id  in  ID_W  tag returned unchanged with the response.
- req_opcode  in  6  instruction opcode field.
- req_funct  in  6  funct field; used only when req_opcode == 0x00.
- req_shamt  in  5  shift amount for constant shifts.
- req_rs_val  in  32  rs register value.
- req_rt_val  in  32  rt register value.
- req_imm  in  16  immediate field.
- alu_control  out  5  to ALU; registered.
- alu_src1  out  32  to ALU; registered.
- alu_src2  out  32  to ALU; registered.
- alu_result  in  32  from ALU; combinational function of the three outputs above.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accepted when resp_valid & resp_ready.
- resp_id  out  ID_W  tag of the response.
- resp_result  out  32  captured ALU result.
- resp_illegal  out  1  request was an unsupported encoding.
- done_count  out  CNT_W  completed responses, saturating.
- illegal_count  out  CNT_W  completed illegal responses, saturating.

Behaviour:
- Reset:
  - s1_valid = s2_valid = 0.
  - alu_control = 0, alu_src1 = 0, alu_src2 = 0.
  - resp_valid = 0, resp_id = 0, resp_result = 0, resp_illegal = 0.
  - Both counters = 0.
  - Reset mid-operation discards in-flight requests with no response.
- Flow control:
  - s2_free = ~s2_valid | resp_ready.
  - s1_adv = s1_valid & s2_free.
  - req_ready = ~s1_valid | s2_free. This is combinational and equals 1 in the cycle after reset.
- Stage 1 (issue), on accept:
  - Register the encoded control, operands, id and illegal flag.
  - s1_valid <= 1, otherwise s1_valid <= s1_valid & ~s2_free.
  - The registered outputs drive the ALU directly and hold stable while s1_valid & ~s2_free.
- Stage 2 (capture), when s1_adv:
  - resp_result <= (s1_illegal ? 0 : alu_result); resp_id <= s1_id; resp_illegal <= s1_illegal; s2_valid <= 1.
  - Else if resp_ready: s2_valid <= 0.
  - Simultaneous resp handshake and s1_adv: the new response replaces the old one, with no bubble.
- Latency: accept in cycle N → resp_valid in cycle N+2.
- Backpressure: resp_* remain stable while resp_valid & ~resp_ready. With both stages full, req_ready = 0.
- Encoding, R-type (opcode 0x00; src1 = rs, src2 = rt unless noted):
  - 0x20 add→12, 0x22 sub→11, 0x2A slt→10, 0x2B sltu→9.
  - 0x24 and→8, 0x27 nor→7, 0x25 or→6, 0x26 xor→5.
  - 0x00 sll→4, 0x02 srl→3, 0x03 sra→2, each with src1 = {27'b0, shamt}.
  - 0x04 sllv→4, 0x06 srlv→3, 0x07 srav→2, each with src1 = rs.
  - Extensions: 0x30 cmp→13, 0x31 cmpu→14, 0x32 nand→15, 0x33 xnor→16, 0x34 lli→17, 0x35 sgtu→18.
- Encoding, I-type (src1 = rs):
  - 0x08 addi→12, 0x0A slti→10, 0x0B sltiu→9, each with src2 = sign-extended imm.
  - 0x0C andi→8, 0x0D ori→6, 0x0E xori→5, each with src2 = zero-extended imm.
  - 0x0F lui→1 with src2 = {16'b0, imm}.
- Illegal encoding: any other opcode/funct gives control = 0, src1 = src2 = 0, illegal = 1, and the response is still returned.
- Counters:
  - done_count increments on each resp handshake.
  - illegal_count increments on each resp handshake where resp_illegal = 1.
  - Both hold at all-ones.

Decomposition:
- Package alu_issue_pkg:
  - ALU control code constants (ALU_ADD = 12 … ALU_SGTU = 18, ALU_NOP = 0).
  - OPC_* and FN_* encoding constants.
- Sub-module alu_issue_dec: purely combinational; maps opcode/funct/shamt/rs/rt/imm to {control, src1, src2, illegal}.
- Top level: pipeline registers, flow control and counters.

Test Plan:
- add: rs = 5, rt = 7, funct 0x20, resp_ready = 1 → two cycles later resp_result = 12, resp_id echoed, alu_control was 12 during issue.
- Constant shift and lui:
  - sll with rt = 0x1, shamt = 31 → resp_result = 0x80000000.
  - lui with imm = 0xABCD → resp_result = 0xABCD0000.
- Immediate extension:
  - addi with rs = 0, imm = 0xFFFF → 0xFFFFFFFF.
  - ori with rs = 0, imm = 0xFFFF → 0x0000FFFF.
- Illegal and counters: opcode 0x3F → resp_illegal = 1, resp_result = 0; illegal_count and done_count both increment by 1.
- Backpressure: issue 3 back-to-back requests with resp_ready = 0 → req_ready drops after 2 accepts, resp_* stable. Release resp_ready → ids return in order, no loss or duplication.
- Reset mid-flight: assert reset with both stages full → next cycle resp_valid = 0, counters = 0, req_ready = 1, and no stale response appears afterwards.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue stage: ALU control codes, MIPS opcode/funct
// values and the decoder result bundle.
package alu_issue_pkg;

  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_LUI  = 5'd1;
  localparam logic [4:0] ALU_SRA  = 5'd2;
  localparam logic [4:0] ALU_SRL  = 5'd3;
  localparam logic [4:0] ALU_SLL  = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;
  localparam logic [4:0] ALU_NOR  = 5'd7;
  localparam logic [4:0] ALU_AND  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_SLT  = 5'd10;
  localparam logic [4:0] ALU_SUB  = 5'd11;
  localparam logic [4:0] ALU_ADD  = 5'd12;
  localparam logic [4:0] ALU_CMP  = 5'd13;
  localparam logic [4:0] ALU_CMPU = 5'd14;
  localparam logic [4:0] ALU_NAND = 5'd15;
  localparam logic [4:0] ALU_XNOR = 5'd16;
  localparam logic [4:0] ALU_LLI  = 5'd17;
  localparam logic [4:0] ALU_SGTU = 5'd18;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [5:0] FN_CMP  = 6'h30;
  localparam logic [5:0] FN_CMPU = 6'h31;
  localparam logic [5:0] FN_NAND = 6'h32;
  localparam logic [5:0] FN_XNOR = 6'h33;
  localparam logic [5:0] FN_LLI  = 6'h34;
  localparam logic [5:0] FN_SGTU = 6'h35;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational instruction decoder: opcode/funct to ALU control code plus the
// operand selection for src1/src2. Unsupported encodings yield a zeroed NOP.
module alu_issue_dec
  import alu_issue_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic [4:0]  shamt_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [15:0] imm_i,
  output dec_t        dec_o
);

  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] shamt_ext;

  assign imm_sext  = {{16{imm_i[15]}}, imm_i};
  assign imm_zext  = {16'b0, imm_i};
  assign shamt_ext = {27'b0, shamt_i};

  always_comb begin
    dec_o         = '0;
    dec_o.src1    = rs_i;
    dec_o.src2    = rt_i;
    dec_o.ctrl    = ALU_NOP;
    dec_o.illegal = 1'b0;
    case (opcode_i)
      OPC_RTYPE: begin
        case (funct_i)
          FN_ADD:  dec_o.ctrl = ALU_ADD;
          FN_SUB:  dec_o.ctrl = ALU_SUB;
          FN_SLT:  dec_o.ctrl = ALU_SLT;
          FN_SLTU: dec_o.ctrl = ALU_SLTU;
          FN_AND:  dec_o.ctrl = ALU_AND;
          FN_NOR:  dec_o.ctrl = ALU_NOR;
          FN_OR:   dec_o.ctrl = ALU_OR;
          FN_XOR:  dec_o.ctrl = ALU_XOR;
          FN_SLL:  begin dec_o.ctrl = ALU_SLL; dec_o.src1 = shamt_ext; end
          FN_SRL:  begin dec_o.ctrl = ALU_SRL; dec_o.src1 = shamt_ext; end
          FN_SRA:  begin dec_o.ctrl = ALU_SRA; dec_o.src1 = shamt_ext; end
          FN_SLLV: dec_o.ctrl = ALU_SLL;
          FN_SRLV: dec_o.ctrl = ALU_SRL;
          FN_SRAV: dec_o.ctrl = ALU_SRA;
          FN_CMP:  dec_o.ctrl = ALU_CMP;
          FN_CMPU: dec_o.ctrl = ALU_CMPU;
          FN_NAND: dec_o.ctrl = ALU_NAND;
          FN_XNOR: dec_o.ctrl = ALU_XNOR;
          FN_LLI:  dec_o.ctrl = ALU_LLI;
          FN_SGTU: dec_o.ctrl = ALU_SGTU;
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OPC_ADDI:  begin dec_o.ctrl = ALU_ADD;  dec_o.src2 = imm_sext; end
      OPC_SLTI:  begin dec_o.ctrl = ALU_SLT;  dec_o.src2 = imm_sext; end
      OPC_SLTIU: begin dec_o.ctrl = ALU_SLTU; dec_o.src2 = imm_sext; end
      OPC_ANDI:  begin dec_o.ctrl = ALU_AND;  dec_o.src2 = imm_zext; end
      OPC_ORI:   begin dec_o.ctrl = ALU_OR;   dec_o.src2 = imm_zext; end
      OPC_XORI:  begin dec_o.ctrl = ALU_XOR;  dec_o.src2 = imm_zext; end
      OPC_LUI:   begin dec_o.ctrl = ALU_LUI;  dec_o.src2 = imm_zext; end
      default:   dec_o.illegal = 1'b1;
    endcase
    // Illegal requests still flow through the pipe, but present a quiet ALU.
    if (dec_o.illegal) begin
      dec_o.ctrl = ALU_NOP;
      dec_o.src1 = '0;
      dec_o.src2 = '0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Two-stage ALU issue pipe: stage 1 registers decoded control/operands toward the
// combinational ALU, stage 2 captures its result as the response.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ID_W-1:0]  req_id,
  input  logic [5:0]       req_opcode,
  input  logic [5:0]       req_funct,
  input  logic [4:0]       req_shamt,
  input  logic [31:0]      req_rs_val,
  input  logic [31:0]      req_rt_val,
  input  logic [15:0]      req_imm,
  output logic [4:0]       alu_control,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  input  logic [31:0]      alu_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [ID_W-1:0]  resp_id,
  output logic [31:0]      resp_result,
  output logic             resp_illegal,
  output logic [CNT_W-1:0] done_count,
  output logic [CNT_W-1:0] illegal_count
);

  dec_t dec;

  alu_issue_dec u_dec (
    .opcode_i (req_opcode),
    .funct_i  (req_funct),
    .shamt_i  (req_shamt),
    .rs_i     (req_rs_val),
    .rt_i     (req_rt_val),
    .imm_i    (req_imm),
    .dec_o    (dec)
  );

  logic             s1_valid_q, s1_valid_d, s1_illegal_q;
  logic [ID_W-1:0]  s1_id_q;
  logic [4:0]       ctrl_q;
  logic [31:0]      src1_q, src2_q;
  logic             s2_valid_q, s2_valid_d, resp_illegal_q;
  logic [ID_W-1:0]  resp_id_q;
  logic [31:0]      resp_result_q;
  logic [CNT_W-1:0] done_q, done_d, ill_cnt_q, ill_cnt_d;
  logic             s2_free, s1_adv, accept, resp_hs;

  assign s2_free   = ~s2_valid_q | resp_ready;
  assign s1_adv    = s1_valid_q & s2_free;
  assign req_ready = ~s1_valid_q | s2_free;
  assign accept    = req_valid & req_ready;
  assign resp_hs   = s2_valid_q & resp_ready;

  always_comb begin
    s1_valid_d = accept | (s1_valid_q & ~s2_free);
    s2_valid_d = s1_adv | (s2_valid_q & ~resp_ready);
    done_d     = done_q;
    ill_cnt_d  = ill_cnt_q;
    // Counters saturate at all-ones rather than wrapping.
    if (resp_hs && (done_q != '1)) done_d = done_q + CNT_W'(1);
    if (resp_hs && resp_illegal_q && (ill_cnt_q != '1)) ill_cnt_d = ill_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q     <= 1'b0;
      s1_illegal_q   <= 1'b0;
      s1_id_q        <= '0;
      ctrl_q         <= '0;
      src1_q         <= '0;
      src2_q         <= '0;
      s2_valid_q     <= 1'b0;
      resp_id_q      <= '0;
      resp_result_q  <= '0;
      resp_illegal_q <= 1'b0;
      done_q         <= '0;
      ill_cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      done_q     <= done_d;
      ill_cnt_q  <= ill_cnt_d;
      if (accept) begin
        ctrl_q       <= dec.ctrl;
        src1_q       <= dec.src1;
        src2_q       <= dec.src2;
        s1_illegal_q <= dec.illegal;
        s1_id_q      <= req_id;
      end
      if (s1_adv) begin
        resp_result_q  <= s1_illegal_q ? '0 : alu_result;
        resp_id_q      <= s1_id_q;
        resp_illegal_q <= s1_illegal_q;
      end
    end
  end

  assign alu_control   = ctrl_q;
  assign alu_src1      = src1_q;
  assign alu_src2      = src2_q;
  assign resp_valid    = s2_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_result   = resp_result_q;
  assign resp_illegal  = resp_illegal_q;
  assign done_count    = done_q;
  assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: acts as the ALU, runs directed scenarios and a randomized
// scoreboard run against an instruction-level reference model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_id;
  logic [5:0]  req_opcode, req_funct;
  logic [4:0]  req_shamt;
  logic [31:0] req_rs_val, req_rt_val;
  logic [15:0] req_imm;
  logic [4:0]  alu_control;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic        resp_valid, resp_ready, resp_illegal;
  logic [3:0]  resp_id;
  logic [31:0] resp_result;
  logic [15:0] done_count, illegal_count;

  int n_cmp = 0;
  int n_err = 0;
  int done_exp = 0;
  int ill_exp = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] result;
    logic        illegal;
  } exp_t;

  alu_issue #(.ID_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_opcode(req_opcode), .req_funct(req_funct), .req_shamt(req_shamt),
    .req_rs_val(req_rs_val), .req_rt_val(req_rt_val), .req_imm(req_imm),
    .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_illegal(resp_illegal),
    .done_count(done_count), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  // Bench-side ALU, defined by control code; code 0 returns junk so forced zeroing shows.
  function automatic logic [31:0] alu_model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      5'd1:  return b << 16;
      5'd2:  return $unsigned($signed(b) >>> a[4:0]);
      5'd3:  return b >> a[4:0];
      5'd4:  return b << a[4:0];
      5'd5:  return a ^ b;
      5'd6:  return a | b;
      5'd7:  return ~(a | b);
      5'd8:  return a & b;
      5'd9:  return {31'b0, a < b};
      5'd10: return {31'b0, $signed(a) < $signed(b)};
      5'd11: return a - b;
      5'd12: return a + b;
      5'd13: return {31'b0, a == b};
      5'd14: return {31'b0, a >= b};
      5'd15: return ~(a & b);
      5'd16: return ~(a ^ b);
      5'd17: return b & 32'h0000FFFF;
      5'd18: return {31'b0, a > b};
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_control, alu_src1, alu_src2);

  // Instruction-level reference: what the response should hold for a request.
  function automatic void ref_exec(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                   input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                                   output logic [31:0] r, output logic ill);
    logic [31:0] se;
    logic [31:0] ze;
    se  = {{16{imm[15]}}, imm};
    ze  = {16'b0, imm};
    r   = 32'h0;
    ill = 1'b0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: r = rs + rt;
        6'h22: r = rs - rt;
        6'h2A: r = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
        6'h2B: r = (rs < rt) ? 32'd1 : 32'd0;
        6'h24: r = rs & rt;
        6'h27: r = ~(rs | rt);
        6'h25: r = rs | rt;
        6'h26: r = rs ^ rt;
        6'h00: r = rt << sh;
        6'h02: r = rt >> sh;
        6'h03: r = $unsigned($signed(rt) >>> sh);
        6'h04: r = rt << rs[4:0];
        6'h06: r = rt >> rs[4:0];
        6'h07: r = $unsigned($signed(rt) >>> rs[4:0]);
        6'h30: r = (rs == rt) ? 32'd1 : 32'd0;
        6'h31: r = (rs >= rt) ? 32'd1 : 32'd0;
        6'h32: r = ~(rs & rt);
        6'h33: r = ~(rs ^ rt);
        6'h34: r = {16'b0, rt[15:0]};
        6'h35: r = (rs > rt) ? 32'd1 : 32'd0;
        default: ill = 1'b1;
      endcase
    end else begin
      case (op)
        6'h08: r = rs + se;
        6'h0A: r = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
        6'h0B: r = (rs < se) ? 32'd1 : 32'd0;
        6'h0C: r = rs & ze;
        6'h0D: r = rs | ze;
        6'h0E: r = rs ^ ze;
        6'h0F: r = {imm, 16'b0};
        default: ill = 1'b1;
      endcase
    end
  endfunction

  // Counter model: every response handshake since the last reset.
  always @(negedge clk) begin
    if (reset) begin
      done_exp <= 0;
      ill_exp  <= 0;
    end else if (resp_valid && resp_ready) begin
      done_exp <= done_exp + 1;
      if (resp_illegal) ill_exp <= ill_exp + 1;
    end
  end

  task automatic set_req(input logic [3:0] id, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
    req_id = id; req_opcode = op; req_funct = fn; req_shamt = sh;
    req_rs_val = rs; req_rt_val = rt; req_imm = imm;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Issues the request already on the inputs and waits (bounded) for its response.
  task automatic issue_and_wait(output logic got, output logic [3:0] id, output logic [31:0] res, output logic ill);
    logic acc;
    got = 1'b0; acc = 1'b0; id = '0; res = '0; ill = 1'b0;
    req_valid = 1'b1; resp_ready = 1'b1;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (acc && resp_valid) begin
        got = 1'b1; id = resp_id; res = resp_result; ill = resp_illegal;
      end
      if (req_valid && req_ready) acc = 1'b1;
      next_cycle();
      if (acc) req_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); end
    n_cmp++; if (resp_id !== 4'h0) begin n_err++; $display("FAIL reset_resp_id got=%h exp=0", resp_id); end
    n_cmp++; if (resp_result !== 32'h0) begin n_err++; $display("FAIL reset_resp_result got=%h exp=0", resp_result); end
    n_cmp++; if (resp_illegal !== 1'b0) begin n_err++; $display("FAIL reset_resp_illegal got=%0b exp=0", resp_illegal); end
    n_cmp++; if ({alu_control, alu_src1, alu_src2} !== 69'h0) begin n_err++; $display("FAIL reset_alu_regs got=%h/%h/%h exp=0", alu_control, alu_src1, alu_src2); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    n_cmp++; if ({done_count, illegal_count} !== 32'h0) begin n_err++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", done_count, illegal_count); end
    $display("test_reset: done");
  endtask

  task automatic test_add();
    set_req(4'hA, 6'h00, 6'h20, 5'd0, 32'd5, 32'd7, 16'h0);
    req_valid = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL add_req_ready got=%0b exp=1", req_ready); end
    next_cycle();
    req_valid = 1'b0;
    n_cmp++; if (alu_control !== 5'd12 || alu_src1 !== 32'd5 || alu_src2 !== 32'd7) begin
      n_err++; $display("FAIL add_issue got=%0d/%0d/%0d exp=12/5/7", alu_control, alu_src1, alu_src2); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL add_early_resp got=%0b exp=0", resp_valid); end
    next_cycle();
    n_cmp++; if (resp_valid !== 1'b1 || resp_result !== 32'd12 || resp_id !== 4'hA || resp_illegal !== 1'b0) begin
      n_err++; $display("FAIL add_resp got=v%0b r=%0d id=%h i=%0b exp=v1 r=12 id=a i=0", resp_valid, resp_result, resp_id, resp_illegal); end
    next_cycle();
    n_cmp++; if (resp_valid !== 1'b0 || done_count !== 16'(done_exp) || done_exp != 1) begin
      n_err++; $display("FAIL add_done got=v%0b cnt=%0d exp=v0 cnt=1", resp_valid, done_count); end
    $display("test_add: id=a result=%0d", resp_result);
  endtask

  task automatic test_shift_lui();
    logic got, ill; logic [3:0] id; logic [31:0] res;
    set_req(4'h3, 6'h00, 6'h00, 5'd31, 32'h12345678, 32'h1, 16'h0);
    issue_and_wait(got, id, res, ill);
    n_cmp++; if (!got || res !== 32'h80000000 || id !== 4'h3) begin
      n_err++; $display("FAIL sll31 got=%0b/%h/%h exp=1/80000000/3", got, res, id); end
    $display("test_shift_lui: sll result=%h", res);
    set_req(4'h4, 6'h0F, 6'h00, 5'd0, 32'hFFFFFFFF, 32'h0, 16'hABCD);
    issue_and_wait(got, id, res, ill);
    n_cmp++; if (!got || res !== 32'hABCD0000 || id !== 4'h4) begin
      n_err++; $display("FAIL lui got=%0b/%h/%h exp=1/abcd0000/4", got, res, id); end
    $display("test_shift_lui: lui result=%h", res);
  endtask

  task automatic test_imm();
    logic got, ill; logic [3:0] id; logic [31:0] res;
    set_req(4'h5, 6'h08, 6'h00, 5'd0, 32'h0, 32'h0, 16'hFFFF);
    issue_and_wait(got, id, res, ill);
    n_cmp++; if (!got || res !== 32'hFFFFFFFF) begin n_err++; $display("FAIL addi_sext got=%0b/%h exp=1/ffffffff", got, res); end
    $display("test_imm: addi result=%h", res);
    set_req(4'h6, 6'h0D, 6'h00, 5'd0, 32'h0, 32'h0, 16'hFFFF);
    issue_and_wait(got, id, res, ill);
    n_cmp++; if (!got || res !== 32'h0000FFFF) begin n_err++; $display("FAIL ori_zext got=%0b/%h exp=1/0000ffff", got, res); end
    $display("test_imm: ori result=%h", res);
  endtask

  task automatic test_illegal();
    logic got, ill; logic [3:0] id; logic [31:0] res;
    int d0, i0;
    d0 = done_exp; i0 = ill_exp;
    set_req(4'h7, 6'h3F, 6'h20, 5'd3, 32'h11, 32'h22, 16'h1234);
    issue_and_wait(got, id, res, ill);
    n_cmp++; if (!got || ill !== 1'b1 || res !== 32'h0 || id !== 4'h7) begin
      n_err++; $display("FAIL illegal_resp got=%0b ill=%0b r=%h id=%h exp=1 ill=1 r=0 id=7", got, ill, res, id); end
    next_cycle();
    n_cmp++; if (done_count !== 16'(d0 + 1) || illegal_count !== 16'(i0 + 1)) begin
      n_err++; $display("FAIL illegal_counts got=%0d/%0d exp=%0d/%0d", done_count, illegal_count, d0 + 1, i0 + 1); end
    $display("test_illegal: done=%0d illegal=%0d", done_count, illegal_count);
  endtask

  task automatic test_backpressure();
    int acc;
    logic [3:0] hid; logic [31:0] hres;
    logic [3:0] got_id[$];
    logic [31:0] got_res[$];
    acc = 0; hid = '0; hres = '0;
    resp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid = (acc < 3);
      set_req(4'(acc + 1), 6'h00, 6'h20, 5'd0, 32'(acc + 1), 32'h0, 16'h0);
      @(negedge clk);
      if (c >= 2) begin
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready c=%0d got=%0b exp=0", c, req_ready); end
      end
      if (c == 2) begin hid = resp_id; hres = resp_result; end
      if (c > 2) begin
        n_cmp++; if (resp_valid !== 1'b1 || resp_id !== hid || resp_result !== hres || hid !== 4'h1) begin
          n_err++; $display("FAIL bp_stable c=%0d got=v%0b id=%h r=%h exp=v1 id=1 r=%h", c, resp_valid, resp_id, resp_result, hres); end
      end
      if (req_valid && req_ready) acc++;
      next_cycle();
    end
    n_cmp++; if (acc != 2) begin n_err++; $display("FAIL bp_accepts got=%0d exp=2", acc); end
    for (int c = 0; c < 10; c++) begin
      resp_ready = 1'b1;
      req_valid = (acc < 3);
      set_req(4'(acc + 1), 6'h00, 6'h20, 5'd0, 32'(acc + 1), 32'h0, 16'h0);
      @(negedge clk);
      if (resp_valid && resp_ready) begin got_id.push_back(resp_id); got_res.push_back(resp_result); end
      if (req_valid && req_ready) acc++;
      next_cycle();
    end
    req_valid = 1'b0;
    n_cmp++; if (got_id.size() != 3) begin n_err++; $display("FAIL bp_count got=%0d exp=3", got_id.size()); end
    for (int i = 0; i < got_id.size() && i < 3; i++) begin
      n_cmp++; if (got_id[i] !== 4'(i + 1) || got_res[i] !== 32'(i + 1)) begin
        n_err++; $display("FAIL bp_order i=%0d got=%h/%0d exp=%0d/%0d", i, got_id[i], got_res[i], i + 1, i + 1); end
    end
    $display("test_backpressure: returned %0d responses", got_id.size());
  endtask

  task automatic test_random();
    logic [11:0] legal_tab [27];
    exp_t sb[$];
    exp_t e, p;
    logic hold;
    logic [3:0] hid; logic [31:0] hres; logic hill;
    logic [11:0] ent;
    int ncheck;
    legal_tab = '{12'h020, 12'h022, 12'h02A, 12'h02B, 12'h024, 12'h027, 12'h025, 12'h026, 12'h000,
                  12'h002, 12'h003, 12'h004, 12'h006, 12'h007, 12'h030, 12'h031, 12'h032, 12'h033,
                  12'h034, 12'h035, 12'h200, 12'h280, 12'h2C0, 12'h300, 12'h340, 12'h380, 12'h3C0};
    hold = 1'b0; hid = '0; hres = '0; hill = 1'b0; ncheck = 0;
    for (int c = 0; c < 400; c++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      ent = legal_tab[$urandom_range(0, 26)];
      req_opcode = ent[11:6];
      req_funct  = (ent[11:6] == 6'h00) ? ent[5:0] : 6'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        req_opcode = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'h23;
        req_funct  = 6'h3F;
      end
      req_id     = 4'($urandom);
      req_shamt  = 5'($urandom);
      req_rs_val = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      req_rt_val = ($urandom_range(0, 3) == 0) ? req_rs_val : $urandom;
      req_imm    = 16'($urandom);
      @(negedge clk);
      if (hold) begin
        n_cmp++; if (resp_valid !== 1'b1 || resp_id !== hid || resp_result !== hres || resp_illegal !== hill) begin
          n_err++; $display("FAIL rnd_stable c=%0d got=v%0b %h/%h/%0b exp=v1 %h/%h/%0b", c, resp_valid, resp_id, resp_result, resp_illegal, hid, hres, hill); end
      end
      if (resp_valid && resp_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL rnd_unexpected c=%0d got id=%h exp=none", c, resp_id);
        end else begin
          p = sb.pop_front();
          ncheck++;
          if (resp_id !== p.id || resp_result !== p.result || resp_illegal !== p.illegal) begin
            n_err++; $display("FAIL rnd_resp c=%0d got=%h/%h/%0b exp=%h/%h/%0b", c, resp_id, resp_result, resp_illegal, p.id, p.result, p.illegal);
          end
        end
      end
      hold = resp_valid && !resp_ready;
      hid = resp_id; hres = resp_result; hill = resp_illegal;
      if (req_valid && req_ready) begin
        e.id = req_id;
        ref_exec(req_opcode, req_funct, req_shamt, req_rs_val, req_rt_val, req_imm, e.result, e.illegal);
        sb.push_back(e);
      end
      next_cycle();
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL rnd_drain_extra got id=%h exp=none", resp_id);
        end else begin
          p = sb.pop_front();
          ncheck++;
          if (resp_id !== p.id || resp_result !== p.result || resp_illegal !== p.illegal) begin
            n_err++; $display("FAIL rnd_drain got=%h/%h/%0b exp=%h/%h/%0b", resp_id, resp_result, resp_illegal, p.id, p.result, p.illegal);
          end
        end
      end
      next_cycle();
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL rnd_lost got=%0d pending exp=0", sb.size()); end
    n_cmp++; if (done_count !== 16'(done_exp) || illegal_count !== 16'(ill_exp)) begin
      n_err++; $display("FAIL rnd_counts got=%0d/%0d exp=%0d/%0d", done_count, illegal_count, done_exp, ill_exp); end
    $display("test_random: %0d responses checked, done=%0d illegal=%0d", ncheck, done_count, illegal_count);
  endtask

  task automatic test_reset_midflight();
    resp_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      req_valid = 1'b1;
      set_req(4'(c + 8), 6'h00, 6'h20, 5'd0, 32'd100, 32'(c), 16'h0);
      next_cycle();
    end
    req_valid = 1'b0;
    n_cmp++; if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_full got=ready%0b v%0b exp=ready0 v1", req_ready, resp_valid); end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    n_cmp++; if (resp_valid !== 1'b0 || done_count !== 16'h0 || illegal_count !== 16'h0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_reset got=v%0b cnt=%0d/%0d ready=%0b exp=v0 cnt=0/0 ready=1", resp_valid, done_count, illegal_count, req_ready); end
    resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale c=%0d got id=%h exp=no response", c, resp_id); end
      next_cycle();
    end
    $display("test_reset_midflight: done");
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    set_req(4'h0, 6'h00, 6'h00, 5'd0, 32'h0, 32'h0, 16'h0);
    repeat (3) next_cycle();
    reset = 1'b0;
    test_reset();
    test_add();
    test_shift_lui();
    test_imm();
    test_illegal();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
